// File: rtl/conv_result_writeback_if.sv
// Output-buffer write port of conv_result_writeback: ready-gated write of one
// requantized element per accepted cycle.
interface conv_result_writeback_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned OUT_W  = 16
) ();
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [OUT_W-1:0]  wr_data;
  logic              wr_ready;

  modport master (output wr_en, output wr_addr, output wr_data, input  wr_ready);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data, output wr_ready);
endinterface

// File: rtl/conv_result_writeback.sv
// Result-tile writeback: counts the accumulator tile stream, masks padding, requantizes
// and writes kept elements through a small FIFO. Optional ReLU: define CONV_WB_RELU_EN.
module conv_result_writeback #(
  parameter int unsigned S2P_SIZE   = 8,
  parameter int unsigned RESULT_W   = 32,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned CNT_W      = 12,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       i_start,
  input  logic signed [RESULT_W-1:0] i_result,
  input  logic [2:0]                 i_result_valid,
  input  logic [CNT_W-1:0]           cfg_t_num,
  input  logic [CNT_W-1:0]           cfg_w_num,
  input  logic [CNT_W-1:0]           cfg_out_pixels,
  input  logic [CNT_W-1:0]           cfg_kernel_nums,
  input  logic [4:0]                 cfg_shift,
  conv_result_writeback_if.master    wr,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_overflow
);
  localparam int unsigned TILE_ELEMS = S2P_SIZE * S2P_SIZE;
  localparam int unsigned EW  = (TILE_ELEMS > 1) ? $clog2(TILE_ELEMS) : 1;
  localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCW = PW + 1;
  localparam int unsigned MW  = 2 * CNT_W + 8;
  localparam logic signed [RESULT_W-1:0] SAT_MAX = {{(RESULT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RESULT_W-1:0] SAT_MIN = {{(RESULT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [OUT_W-1:0]  data;
  } wb_entry_t;

  state_t          state_q, state_d;
  logic            busy_d, done_d;
  logic [EW-1:0]   elem_cnt;
  logic [CNT_W-1:0] t_tile, w_tile;
  logic            s1_valid;
  wb_entry_t       s1_entry;
  wb_entry_t       mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [FCW-1:0]  fifo_cnt, cnt_d;
  logic            nempty;

  logic unused_tile_start;
  assign unused_tile_start = i_result_valid[2];

  // Tile position of the element currently presented
  logic count_c, elem_last_c, t_last_c, w_last_c, final_c, keep_c;
  logic [MW-1:0] row_c, col_c, pix_c, ch_c;
  logic [ADDR_W-1:0] addr_c;

  assign count_c     = (state_q == RUN) && i_result_valid[1] && !i_start;
  assign elem_last_c = (elem_cnt == EW'(TILE_ELEMS - 1));
  assign t_last_c    = (t_tile == cfg_t_num - CNT_W'(1));
  assign w_last_c    = (w_tile == cfg_w_num - CNT_W'(1));
  assign final_c     = count_c && elem_last_c && t_last_c && w_last_c;

  assign row_c  = MW'(elem_cnt) % MW'(S2P_SIZE);
  assign col_c  = MW'(elem_cnt) / MW'(S2P_SIZE);
  assign pix_c  = MW'(t_tile) * MW'(S2P_SIZE) + row_c;
  assign ch_c   = MW'(w_tile) * MW'(S2P_SIZE) + col_c;
  assign keep_c = count_c && i_result_valid[0] &&
                  (pix_c < MW'(cfg_out_pixels)) && (ch_c < MW'(cfg_kernel_nums));
  assign addr_c = ADDR_W'(ch_c * MW'(cfg_out_pixels) + pix_c);

  // Requantization: arithmetic shift, optional ReLU, saturate to OUT_W
  logic signed [RESULT_W-1:0] shifted_c, relu_c;
  logic [OUT_W-1:0] sat_c;

  assign shifted_c = i_result >>> cfg_shift;
`ifdef CONV_WB_RELU_EN
  assign relu_c = shifted_c[RESULT_W-1] ? '0 : shifted_c;
`else
  assign relu_c = shifted_c;
`endif

  always_comb begin
    sat_c = relu_c[OUT_W-1:0];
    if (relu_c > SAT_MAX)      sat_c = SAT_MAX[OUT_W-1:0];
    else if (relu_c < SAT_MIN) sat_c = SAT_MIN[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      elem_cnt <= '0;
      t_tile   <= '0;
      w_tile   <= '0;
    end else if (i_start) begin
      elem_cnt <= '0;
      t_tile   <= '0;
      w_tile   <= '0;
    end else if (count_c) begin
      if (elem_last_c) begin
        elem_cnt <= '0;
        if (t_last_c) begin
          t_tile <= '0;
          w_tile <= w_tile + CNT_W'(1);
        end else begin
          t_tile <= t_tile + CNT_W'(1);
        end
      end else begin
        elem_cnt <= elem_cnt + EW'(1);
      end
    end
  end

  // Single register stage between the stream and the FIFO push
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_entry <= '0;
    end else begin
      s1_valid <= keep_c;
      if (keep_c) s1_entry <= '{addr: addr_c, data: sat_c};
    end
  end

  // Write FIFO; a push into a full FIFO is only accepted when the head pops
  logic pop_c, full_c, push_ok_c;
  assign pop_c     = nempty && wr.wr_ready && !i_start;
  assign full_c    = (fifo_cnt == FCW'(FIFO_DEPTH));
  assign push_ok_c = s1_valid && !i_start && (!full_c || pop_c);
  assign cnt_d     = fifo_cnt + FCW'(push_ok_c) - FCW'(pop_c);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      nempty     <= 1'b0;
      o_overflow <= 1'b0;
    end else if (i_start) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      nempty     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)     rd_ptr <= rd_ptr + PW'(1);
      fifo_cnt <= cnt_d;
      nempty   <= (cnt_d != '0);
      if (s1_valid && full_c && !pop_c) o_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= s1_entry;
  end

  assign wr.wr_en   = nempty;
  assign wr.wr_addr = mem[rd_ptr].addr;
  assign wr.wr_data = mem[rd_ptr].data;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      state_q <= state_d;
      o_busy  <= busy_d;
      o_done  <= done_d;
    end
  end

  // Next state; DRAIN waits for both the pipeline register and the FIFO to empty
  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    if (i_start) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (final_c) state_d = DRAIN;
        DRAIN:   if (!nempty && !s1_valid) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end
endmodule

// File: tb/tb_conv_result_writeback.sv
// Directed self-checking bench for conv_result_writeback with a 4x4 tile.
module tb_conv_result_writeback;
  localparam int unsigned S2P = 4;
  localparam int unsigned RW  = 32;
  localparam int unsigned OW  = 16;
  localparam int unsigned AW  = 16;
  localparam int unsigned CW  = 12;

  logic clk = 1'b0;
  logic rstn, i_start;
  logic signed [RW-1:0] i_result;
  logic [2:0] i_result_valid;
  logic [CW-1:0] cfg_t_num, cfg_w_num, cfg_out_pixels, cfg_kernel_nums;
  logic [4:0] cfg_shift;
  logic o_busy, o_done, o_overflow;

  conv_result_writeback_if #(.ADDR_W(AW), .OUT_W(OW)) wr_if ();

  conv_result_writeback #(
    .S2P_SIZE(S2P), .RESULT_W(RW), .OUT_W(OW), .ADDR_W(AW), .CNT_W(CW), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_result(i_result),
    .i_result_valid(i_result_valid), .cfg_t_num(cfg_t_num), .cfg_w_num(cfg_w_num),
    .cfg_out_pixels(cfg_out_pixels), .cfg_kernel_nums(cfg_kernel_nums),
    .cfg_shift(cfg_shift), .wr(wr_if.master), .o_busy(o_busy), .o_done(o_done),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [AW-1:0]        cap_a[$];
  logic signed [OW-1:0] cap_d[$];

  // Record every accepted write
  always @(negedge clk) begin
    if (rstn && wr_if.wr_en && wr_if.wr_ready) begin
      cap_a.push_back(wr_if.wr_addr);
      cap_d.push_back(wr_if.wr_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [RW-1:0] r, input logic [2:0] v);
    i_result = r;
    i_result_valid = v;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    i_result_valid = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_start();
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic set_cfg(input int t, input int w, input int op, input int kn, input int sh);
    cfg_t_num = CW'(t); cfg_w_num = CW'(w);
    cfg_out_pixels = CW'(op); cfg_kernel_nums = CW'(kn); cfg_shift = 5'(sh);
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = 0;
    i_result_valid = '0;
    while (!o_done && lat < budget) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (o_done !== 1'b1) begin
      bad++;
      $display("FAIL done_timeout: o_done=%b after %0d cycles, required 1", o_done, lat);
    end
  endtask

  task automatic check_count(input string name, input int req);
    total++;
    if (cap_a.size() != req) begin
      bad++;
      $display("FAIL %s_count: got %0d writes, required %0d", name, cap_a.size(), req);
    end
  endtask

  task automatic check_write(input string name, input int idx, input int ea, input int ed);
    logic [AW-1:0] a;
    logic signed [OW-1:0] d;
    a = AW'(ea);
    d = OW'(ed);
    total++;
    if (idx >= cap_a.size()) begin
      bad++;
      $display("FAIL %s_w%0d: write missing, required addr=%0d data=%0d", name, idx, a, d);
    end else if (cap_a[idx] !== a || cap_d[idx] !== d) begin
      bad++;
      $display("FAIL %s_w%0d: got addr=%0d data=%0d, required addr=%0d data=%0d",
               name, idx, cap_a[idx], cap_d[idx], a, d);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; i_start = 1'b0; i_result = '0; i_result_valid = '0;
    wr_if.wr_ready = 1'b1;
    set_cfg(1, 1, 16, 4, 0);
    #12;
    total++;
    if ({wr_if.wr_en, o_busy, o_done, o_overflow} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outputs: wr_en/busy/done/ovf=%b, required 0000",
               {wr_if.wr_en, o_busy, o_done, o_overflow});
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_tile();
    int lat;
    set_cfg(1, 1, 16, 4, 0);
    cap_a.delete(); cap_d.delete();
    do_start();
    total++;
    if (o_busy !== 1'b1) begin
      bad++;
      $display("FAIL single_busy: o_busy=%b, required 1", o_busy);
    end
    for (int e = 0; e < 16; e++) drive(RW'(e), (e == 0) ? 3'b111 : 3'b011);
    wait_done(20, lat);
    total++;
    if (lat < 2 || lat > 3) begin
      bad++;
      $display("FAIL single_done_latency: got %0d cycles, required 2..3", lat);
    end
    total++;
    if (o_busy !== 1'b0) begin
      bad++;
      $display("FAIL single_busy_after: o_busy=%b, required 0", o_busy);
    end
    check_count("single", 16);
    for (int e = 0; e < 16; e++) check_write("single", e, (e / 4) * 16 + e % 4, e);
  endtask

  task automatic test_ignored_when_done();
    cap_a.delete(); cap_d.delete();
    for (int e = 0; e < 16; e++) drive(RW'(e), 3'b011);
    idle(5);
    check_count("ignored", 0);
    total++;
    if (o_done !== 1'b1) begin
      bad++;
      $display("FAIL ignored_done: o_done=%b, required 1", o_done);
    end
  endtask

  task automatic test_row_padding();
    int lat, k;
    set_cfg(1, 1, 3, 4, 0);
    cap_a.delete(); cap_d.delete();
    do_start();
    for (int e = 0; e < 16; e++) drive(RW'(e + 100), (e % 4 == 3) ? 3'b010 : 3'b011);
    wait_done(20, lat);
    check_count("rowpad", 12);
    k = 0;
    for (int e = 0; e < 16; e++) begin
      if (e % 4 != 3) begin
        check_write("rowpad", k, (e / 4) * 3 + e % 4, e + 100);
        k++;
      end
    end
  endtask

  task automatic test_col_padding();
    int lat;
    set_cfg(1, 1, 16, 2, 0);
    cap_a.delete(); cap_d.delete();
    do_start();
    for (int e = 0; e < 16; e++) drive(RW'(e), 3'b011);
    wait_done(20, lat);
    check_count("colpad", 8);
    for (int e = 0; e < 8; e++) check_write("colpad", e, (e / 4) * 16 + e % 4, e);
  endtask

  task automatic test_two_tiles();
    int lat, k, e, ea;
    int seen[64];
    set_cfg(2, 2, 8, 8, 0);
    cap_a.delete(); cap_d.delete();
    do_start();
    for (int i = 0; i < 64; i++) drive(RW'(i), (i % 16 == 0) ? 3'b111 : 3'b011);
    wait_done(20, lat);
    check_count("two", 64);
    foreach (seen[j]) seen[j] = 0;
    for (int i = 0; i < 64; i++) begin
      k = i / 16; e = i % 16;
      ea = ((k / 2) * 4 + e / 4) * 8 + (k % 2) * 4 + e % 4;
      check_write("two", i, ea, i);
      if (i < cap_a.size() && cap_a[i] < 64) seen[cap_a[i]]++;
    end
    for (int j = 0; j < 64; j++) begin
      total++;
      if (seen[j] != 1) begin
        bad++;
        $display("FAIL two_cover_a%0d: written %0d times, required 1", j, seen[j]);
      end
    end
  endtask

  task automatic test_saturation();
    int lat;
    logic [RW-1:0] va[4], vb[4];
    int ea[4], eb[4];
    va[0] = 32'h0001_2345; va[1] = -32'sd100; va[2] = 32'hFFFF_0000; va[3] = 32'h0000_7FFF;
    vb[0] = -32'sd100; vb[1] = 32'h0001_2345; vb[2] = 32'hFFFF_FFFF; vb[3] = 32'h7FFF_FFFF;
`ifdef CONV_WB_RELU_EN
    ea[0] = 32767; ea[1] = 0;    ea[2] = 0;      ea[3] = 32767;
    eb[0] = 0;     eb[1] = 18641; eb[2] = 0;     eb[3] = 32767;
`else
    ea[0] = 32767; ea[1] = -100; ea[2] = -32768; ea[3] = 32767;
    eb[0] = -25;   eb[1] = 18641; eb[2] = -1;    eb[3] = 32767;
`endif
    set_cfg(1, 1, 16, 1, 0);
    cap_a.delete(); cap_d.delete();
    do_start();
    for (int e = 0; e < 16; e++) drive((e < 4) ? va[e] : RW'(0), 3'b011);
    wait_done(20, lat);
    check_count("sat_s0", 4);
    for (int e = 0; e < 4; e++) check_write("sat_s0", e, e, ea[e]);

    set_cfg(1, 1, 16, 1, 2);
    cap_a.delete(); cap_d.delete();
    do_start();
    for (int e = 0; e < 16; e++) drive((e < 4) ? vb[e] : RW'(0), 3'b011);
    wait_done(20, lat);
    check_count("sat_s2", 4);
    for (int e = 0; e < 4; e++) check_write("sat_s2", e, e, eb[e]);
  endtask

  task automatic test_backpressure();
    int lat;
    set_cfg(1, 1, 16, 4, 0);
    cap_a.delete(); cap_d.delete();
    wr_if.wr_ready = 1'b0;
    do_start();
    for (int e = 0; e < 9; e++) drive(RW'(e), 3'b011);
    total++;
    if (o_overflow !== 1'b0) begin
      bad++;
      $display("FAIL bp_ovf_early: o_overflow=%b, required 0", o_overflow);
    end
    drive(RW'(9), 3'b011);
    total++;
    if (o_overflow !== 1'b1 || wr_if.wr_en !== 1'b1) begin
      bad++;
      $display("FAIL bp_ovf_set: ovf=%b wr_en=%b, required 1 1", o_overflow, wr_if.wr_en);
    end
    for (int e = 10; e < 16; e++) drive(RW'(e), 3'b011);
    idle(4);
    check_count("bp_stalled", 0);
    wr_if.wr_ready = 1'b1;
    wait_done(40, lat);
    check_count("bp", 8);
    for (int e = 0; e < 8; e++) check_write("bp", e, (e / 4) * 16 + e % 4, e);
    total++;
    if (o_overflow !== 1'b1) begin
      bad++;
      $display("FAIL bp_ovf_sticky: o_overflow=%b, required 1", o_overflow);
    end
    do_start();
    total++;
    if ({o_overflow, o_done, o_busy} !== 3'b001) begin
      bad++;
      $display("FAIL restart_clear: ovf/done/busy=%b, required 001", {o_overflow, o_done, o_busy});
    end
  endtask

  task automatic test_reset_midop();
    set_cfg(1, 1, 16, 4, 0);
    wr_if.wr_ready = 1'b0;
    do_start();
    for (int e = 0; e < 5; e++) drive(RW'(e), 3'b011);
    i_result_valid = '0;
    #2 rstn = 1'b0;
    #1;
    total++;
    if ({wr_if.wr_en, o_busy, o_done, o_overflow} !== 4'b0000) begin
      bad++;
      $display("FAIL midop_reset: wr_en/busy/done/ovf=%b, required 0000",
               {wr_if.wr_en, o_busy, o_done, o_overflow});
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    cap_a.delete(); cap_d.delete();
    wr_if.wr_ready = 1'b1;
    idle(10);
    check_count("midop", 0);
    total++;
    if (o_busy !== 1'b0) begin
      bad++;
      $display("FAIL midop_idle: o_busy=%b, required 0", o_busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_ignored_when_done();
    test_row_padding();
    test_col_padding();
    test_two_tiles();
    test_saturation();
    test_backpressure();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/conv_result_writeback.md
Name: conv_result_writeback

Overview:
- Sits directly downstream of the matrix-add accumulator.
- Consumes the serialized S2P_SIZE x S2P_SIZE result tile stream, one element per cycle, together with its 3-bit valid bundle.
- Computes each element's output feature-map address and masks padded rows/columns, including the last-kernel-tile column padding that the accumulator does not apply.
- Requantizes each element, buffers it in a small FIFO and writes it to the output buffer through a ready-gated write port.

Parameters:
- S2P_SIZE, 8, tile edge; one tile = S2P_SIZE*S2P_SIZE elements.
- RESULT_W, 32, accumulator element width, signed.
- OUT_W, 16, written element width, signed.
- ADDR_W, 16, output buffer address width.
- CNT_W, 12, width of the tile-count and size config inputs.
- FIFO_DEPTH, 8, write FIFO entries; power of 2.

Ports:
- clk, in, 1, clock.
- rstn, in, 1, asynchronous active-low reset.
- i_start, in, 1, one-cycle pulse that clears all counters and flags and arms the block.
- i_result, in, RESULT_W, current tile element.
- i_result_valid, in, 3, [1]=raw element valid, [0]=row-padding-masked valid, [2]=tile-start pulse (informational).
- cfg_t_num, in, CNT_W, pixel tiles per kernel tile (>=1).
- cfg_w_num, in, CNT_W, kernel tiles (>=1).
- cfg_out_pixels, in, CNT_W, output pixels per channel.
- cfg_kernel_nums, in, CNT_W, number of kernels.
- cfg_shift, in, 5, arithmetic right shift applied before saturation.
- wr_en, out, 1, output buffer write request.
- wr_addr, out, ADDR_W, write address.
- wr_data, out, OUT_W, write data.
- wr_ready, in, 1, buffer accepts the write this cycle.
- o_busy, out, 1, high in RUN or DRAIN.
- o_done, out, 1, level, set at the DRAIN->DONE transition.
- o_overflow, out, 1, sticky; a FIFO push was dropped.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; counters and FIFO cleared.

FSM: IDLE -> RUN on i_start. RUN -> DRAIN after the last element of the last tile is counted. DRAIN -> DONE when the FIFO is empty and no write is pending. DONE -> RUN on i_start. In any state, i_start clears counters, the FIFO and o_overflow.

Element counting (RUN only):
- elem_cnt increments on each i_result_valid[1] cycle, range 0..S2P_SIZE^2-1.
- row = elem_cnt % S2P_SIZE; col = elem_cnt / S2P_SIZE.
- On wrap: t_tile increments. When t_tile wraps at cfg_t_num-1, w_tile increments.
- The last element is defined as w_tile==cfg_w_num-1, t_tile==cfg_t_num-1, elem_cnt==S2P_SIZE^2-1.
- Elements arriving in IDLE, DRAIN or DONE are ignored.

Element keep rule:
- pix = t_tile*S2P_SIZE+row; ch = w_tile*S2P_SIZE+col.
- An element is kept iff i_result_valid[0] && i_result_valid[1] && pix<cfg_out_pixels && ch<cfg_kernel_nums.
- Kept address = ch*cfg_out_pixels+pix, truncated to ADDR_W.

Requantization:
- v = i_result >>> cfg_shift.
- Saturate v to [-2^(OUT_W-1), 2^(OUT_W-1)-1].

Pipeline:
- Keep, address and requantization are registered in one stage.
- The FIFO push occurs the cycle after the element is presented.

FIFO and write port:
- wr_en = FIFO not empty; wr_addr/wr_data = FIFO head.
- The head pops when wr_en && wr_ready.
- Simultaneous push and pop when full: the push is accepted.
- Push while full without a pop: the entry is dropped and o_overflow is set (sticky until i_start or reset).

Reset mid-operation: asynchronous return to reset state. Any partial tile is discarded.

Optional Feature:
- Macro: CONV_WB_RELU_EN.
- Defined: negative values become 0 after the shift and before saturation.
- Undefined: signed values pass through unchanged.

Test Plan (S2P_SIZE=4):
- Single tile: cfg_t_num=1, cfg_w_num=1, out_pixels=16, kernel_nums=4, shift=0, wr_ready=1; i_result=0..15. Expect 16 writes; element e at addr (e/4)*16+e%4 with data e; o_done set 2-3 cycles after the last element.
- Row padding: out_pixels=3, valid[0] low for row 3. Expect 12 writes; no address with pix==3.
- Column padding: kernel_nums=2. Only col 0 and col 1 are written (8 writes) even though valid[0] is high everywhere.
- Two tiles: cfg_t_num=2, cfg_w_num=2, out_pixels=8, kernel_nums=8. Expect 64 writes covering addresses 0..63 exactly once.
- Saturation: i_result=0x00012345, shift=0, OUT_W=16 writes 0x7FFF; i_result=-100, shift=2 writes -25 (0 with CONV_WB_RELU_EN).
- Backpressure: wr_ready held low for 20 cycles during a tile. o_overflow=1 after the 9th kept element; o_done is still reached after wr_ready returns high.
